// File: rtl/psum_accum_scratch_if.sv
// Stream bundle between the PE array, the input-psum source, the
// partial-sum scratchpad and the output buffer.
//  master: the side that drives PE beats and input psums and consumes the drain
//  slave : the scratchpad itself
interface psum_accum_scratch_if #(
    parameter int PSUM_WIDTH = 33,
    parameter int NUM_CH     = 2
);
    logic                         pe_valid;
    logic                         pe_ready;
    logic [NUM_CH*PSUM_WIDTH-1:0] pe_psum;
    logic                         pe_last;
    logic                         inpsum_valid;
    logic                         inpsum_ready;
    logic [NUM_CH*PSUM_WIDTH-1:0] inpsum_data;
    logic                         out_valid;
    logic                         out_ready;
    logic [NUM_CH*PSUM_WIDTH-1:0] out_data;

    modport master (
        output pe_valid, pe_psum, pe_last, inpsum_valid, inpsum_data, out_ready,
        input  pe_ready, inpsum_ready, out_valid, out_data
    );

    modport slave (
        input  pe_valid, pe_psum, pe_last, inpsum_valid, inpsum_data, out_ready,
        output pe_ready, inpsum_ready, out_valid, out_data
    );
endinterface

// File: rtl/psum_accum_scratch.sv
// Multi-channel partial-sum scratchpad and accumulator.
// Collects one psum per channel per PE beat, either overwriting the entry,
// accumulating onto the previous scratch contents, or adding an external
// input-psum stream. When the row ends, the entries are drained in address
// order to the output buffer.
// Optional feature: define PSUM_SAT_EN to make overflowing adds clamp to the
// most positive / most negative value instead of wrapping.
module psum_accum_scratch #(
    parameter int PSUM_WIDTH = 33,
    parameter int PSUM_DEPTH = 64,
    parameter int ADDR_LEN   = 6,
    parameter int NUM_CH     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    psum_accum_scratch_if.slave   bus,
    output logic                  busy,
    output logic                  done,
    output logic                  full_err,
    output logic                  ovf
);

    localparam int DW = NUM_CH * PSUM_WIDTH;
    localparam logic [ADDR_LEN:0] DEPTH_CNT = (ADDR_LEN+1)'(PSUM_DEPTH);
    localparam logic [ADDR_LEN:0] PTR_ONE   = (ADDR_LEN+1)'(1);

`ifdef PSUM_SAT_EN
    localparam logic [PSUM_WIDTH-1:0] SAT_MAX = {1'b0, {(PSUM_WIDTH-1){1'b1}}};
    localparam logic [PSUM_WIDTH-1:0] SAT_MIN = {1'b1, {(PSUM_WIDTH-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        M_WRITE      = 2'd0,
        M_ACC_SELF   = 2'd1,
        M_ACC_IN     = 2'd2,
        M_DRAIN_ONLY = 2'd3
    } mode_t;

    state_t state;
    state_t state_nx;
    mode_t  mode_q;

    // wr_ptr doubles as the entry count, so it needs one extra bit to reach PSUM_DEPTH
    logic [ADDR_LEN:0]   wr_ptr;
    logic [ADDR_LEN:0]   rd_ptr;
    logic [ADDR_LEN-1:0] wr_addr;
    logic [DW-1:0]       mem [PSUM_DEPTH];
    logic [DW-1:0]       cur_entry;
    logic [DW-1:0]       wr_data;
    logic [NUM_CH-1:0]   ch_ovf;

    logic                  full;
    logic                  beat;
    logic                  drain_load;
    logic                  out_hs;
    logic                  last_hs;
    logic                  out_last;
    logic [PSUM_WIDTH-1:0] pe_c;
    logic [PSUM_WIDTH-1:0] a_c;
    logic [PSUM_WIDTH-1:0] sum_c;
    logic                  ov_c;

    assign full      = (wr_ptr == DEPTH_CNT);
    assign wr_addr   = wr_ptr[ADDR_LEN-1:0];
    assign cur_entry = mem[wr_addr];

    assign bus.pe_ready     = (state == S_ACCUM) && !full &&
                              ((mode_q != M_ACC_IN) || bus.inpsum_valid);
    assign beat             = bus.pe_valid && bus.pe_ready;
    assign bus.inpsum_ready = (mode_q == M_ACC_IN) && beat;

    assign out_hs     = bus.out_valid && bus.out_ready;
    assign last_hs    = (state == S_DRAIN) && out_hs && out_last;
    assign drain_load = (state == S_DRAIN) && (rd_ptr < wr_ptr) &&
                        (!bus.out_valid || bus.out_ready);

    assign busy = (state != S_IDLE);

    // Per-channel new entry value: overwrite, or add onto scratch / input psum with overflow detect
    always_comb begin
        wr_data = '0;
        ch_ovf  = '0;
        pe_c    = '0;
        a_c     = '0;
        sum_c   = '0;
        ov_c    = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            pe_c  = bus.pe_psum[c*PSUM_WIDTH +: PSUM_WIDTH];
            a_c   = (mode_q == M_ACC_IN) ? bus.inpsum_data[c*PSUM_WIDTH +: PSUM_WIDTH]
                                         : cur_entry[c*PSUM_WIDTH +: PSUM_WIDTH];
            sum_c = a_c + pe_c;
            ov_c  = (a_c[PSUM_WIDTH-1] == pe_c[PSUM_WIDTH-1]) &&
                    (sum_c[PSUM_WIDTH-1] != a_c[PSUM_WIDTH-1]);
            if (mode_q == M_WRITE) begin
                wr_data[c*PSUM_WIDTH +: PSUM_WIDTH] = pe_c;
            end else begin
                ch_ovf[c] = ov_c;
`ifdef PSUM_SAT_EN
                if (ov_c) begin
                    wr_data[c*PSUM_WIDTH +: PSUM_WIDTH] = a_c[PSUM_WIDTH-1] ? SAT_MIN : SAT_MAX;
                end else begin
                    wr_data[c*PSUM_WIDTH +: PSUM_WIDTH] = sum_c;
                end
`else
                wr_data[c*PSUM_WIDTH +: PSUM_WIDTH] = sum_c;
`endif
            end
        end
    end

    // Scratch storage has no reset so it can map onto a RAM; the write lands at the
    // edge, so the next beat's combinational read already sees it
    always_ff @(posedge clk) begin
        if (beat) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: start leaves IDLE only, the last PE beat moves to drain, the last drain beat ends the run
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = (mode == 2'd3) ? S_DRAIN : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (beat && bus.pe_last) begin
                    state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (last_hs) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Pointers, latched mode and sticky flags; start is only honoured from IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q   <= M_WRITE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            full_err <= 1'b0;
            ovf      <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= last_hs;
            if ((state == S_IDLE) && start) begin
                mode_q   <= mode_t'(mode);
                wr_ptr   <= (mode == 2'd3) ? DEPTH_CNT : '0;
                rd_ptr   <= '0;
                full_err <= 1'b0;
                ovf      <= 1'b0;
            end else begin
                if (beat) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if ((state == S_ACCUM) && full && bus.pe_valid) begin
                    full_err <= 1'b1;
                end
                if (beat && (|ch_ovf)) begin
                    ovf <= 1'b1;
                end
                if (beat && bus.pe_last) begin
                    rd_ptr <= '0;
                end
                if (drain_load) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
            end
        end
    end

    // Drain output register: one-cycle read latency, holds while the output buffer stalls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            out_last      <= 1'b0;
        end else if (drain_load) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= mem[rd_ptr[ADDR_LEN-1:0]];
            out_last      <= (rd_ptr == (wr_ptr - PTR_ONE));
        end else if (out_hs) begin
            bus.out_valid <= 1'b0;
            out_last      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_psum_accum_scratch.sv
// Scoreboard bench for psum_accum_scratch: stimulus pushes hand-computed drain
// entries into a queue, and a monitor pops and compares them on every drain
// handshake. Covers WRITE, ACC_SELF, ACC_IN, backpressure, overflow, full
// and reset during drain.
module tb_psum_accum_scratch;

    localparam int W  = 33;
    localparam int N  = 2;
    localparam int DW = W * N;

`ifdef PSUM_SAT_EN
    localparam longint EXP_OVF = 64'sd4294967295;
`else
    localparam longint EXP_OVF = -64'sd4294967296;
`endif

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       start = 1'b0;
    logic [1:0] mode  = 2'd0;
    logic       busy;
    logic       done;
    logic       full_err;
    logic       ovf;

    psum_accum_scratch_if #(.PSUM_WIDTH(W), .NUM_CH(N)) bus ();

    psum_accum_scratch dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .full_err (full_err),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    int            checks   = 0;
    int            errors   = 0;
    int            hs_count = 0;
    logic [DW-1:0] exp_q[$];
    logic          stalled  = 1'b0;
    logic [DW-1:0] held     = '0;
    logic [DW-1:0] mon_exp;
    logic          last_in_rdy = 1'b0;

    function automatic logic [DW-1:0] pack2(input longint c0, input longint c1);
        return {W'(c1), W'(c0)};
    endfunction

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic startOp(input logic [1:0] m);
        start = 1'b1;
        mode  = m;
        step();
        start = 1'b0;
        mode  = m ^ 2'b01;
    endtask

    // Offer one PE beat and hold it until accepted (bounded)
    task automatic applyStimulus(input longint p0, input longint p1, input logic last,
                                 input longint i0, input longint i1, input logic inv);
        int   n   = 0;
        logic acc = 1'b0;
        bus.pe_valid     = 1'b1;
        bus.pe_psum      = pack2(p0, p1);
        bus.pe_last      = last;
        bus.inpsum_valid = inv;
        bus.inpsum_data  = pack2(i0, i1);
        while (!acc && n < 50) begin
            @(negedge clk);
            acc         = bus.pe_ready;
            last_in_rdy = bus.inpsum_ready;
            step();
            n++;
        end
        checkOutput("beat_accept", DW'(acc), DW'(1));
        bus.pe_valid     = 1'b0;
        bus.pe_last      = 1'b0;
        bus.inpsum_valid = 1'b0;
    endtask

    task automatic waitDone(input string name);
        int   n    = 0;
        logic seen = 1'b0;
        while (!seen && n < 400) begin
            @(negedge clk);
            seen = done;
            n++;
        end
        checkOutput(name, DW'(seen), DW'(1));
        @(negedge clk);
        checkOutput("done_pulse_width", DW'(done), DW'(0));
        checkOutput("idle_after_done", DW'(busy), DW'(0));
        checkOutput("drain_all_popped", DW'(exp_q.size()), DW'(0));
        step();
    endtask

    task automatic waitHs(input int target);
        int n = 0;
        while (hs_count < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_progress", DW'(hs_count >= target), DW'(1));
    endtask

    // Monitor: compare every drain handshake against the scoreboard, and check stalls hold
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    checkOutput("stall_valid", DW'(bus.out_valid), DW'(1));
                    checkOutput("stall_data", bus.out_data, held);
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL drain_extra: got %h expected no beat", bus.out_data);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        checkOutput("drain_data", bus.out_data, mon_exp);
                    end
                    hs_count++;
                end
                stalled = bus.out_valid && !bus.out_ready;
                held    = bus.out_data;
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #500000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        logic pat [10];
        int   hs_base;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        bus.pe_valid     = 1'b0;
        bus.pe_psum      = '0;
        bus.pe_last      = 1'b0;
        bus.inpsum_valid = 1'b0;
        bus.inpsum_data  = '0;
        bus.out_ready    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        $display("[TB] reset state");
        @(negedge clk);
        checkOutput("rst_busy", DW'(busy), DW'(0));
        checkOutput("rst_done", DW'(done), DW'(0));
        checkOutput("rst_out_valid", DW'(bus.out_valid), DW'(0));
        checkOutput("rst_pe_ready", DW'(bus.pe_ready), DW'(0));
        checkOutput("rst_inpsum_ready", DW'(bus.inpsum_ready), DW'(0));
        checkOutput("rst_full_err", DW'(full_err), DW'(0));
        checkOutput("rst_ovf", DW'(ovf), DW'(0));
        step();

        $display("[TB] WRITE");
        bus.out_ready = 1'b1;
        startOp(2'd0);
        exp_q.push_back(pack2(-346, 819));
        exp_q.push_back(pack2(-155, -776));
        exp_q.push_back(pack2(494, 1));
        applyStimulus(-346, 819, 1'b0, 0, 0, 1'b0);
        applyStimulus(-155, -776, 1'b0, 0, 0, 1'b0);
        applyStimulus(494, 1, 1'b1, 0, 0, 1'b0);
        checkOutput("write_inpsum_ready", DW'(last_in_rdy), DW'(0));
        @(negedge clk);
        checkOutput("drain_entry_valid", DW'(bus.out_valid), DW'(0));
        checkOutput("drain_entry_busy", DW'(busy), DW'(1));
        @(negedge clk);
        checkOutput("drain_first_valid", DW'(bus.out_valid), DW'(1));
        step();
        waitDone("write_done");
        checkOutput("write_ovf", DW'(ovf), DW'(0));

        $display("[TB] ACC_SELF");
        startOp(2'd1);
        exp_q.push_back(pack2(-692, 1638));
        exp_q.push_back(pack2(-310, -1552));
        exp_q.push_back(pack2(988, 2));
        applyStimulus(-346, 819, 1'b0, 0, 0, 1'b0);
        applyStimulus(-155, -776, 1'b0, 0, 0, 1'b0);
        applyStimulus(494, 1, 1'b1, 0, 0, 1'b0);
        waitDone("accself_done");
        checkOutput("accself_ovf", DW'(ovf), DW'(0));

        $display("[TB] ACC_IN");
        startOp(2'd2);
        exp_q.push_back(pack2(15, -5));
        bus.pe_valid     = 1'b1;
        bus.pe_psum      = pack2(5, 5);
        bus.pe_last      = 1'b1;
        bus.inpsum_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("accin_stall_pe_ready", DW'(bus.pe_ready), DW'(0));
            checkOutput("accin_stall_in_ready", DW'(bus.inpsum_ready), DW'(0));
            step();
        end
        applyStimulus(5, 5, 1'b1, 10, -10, 1'b1);
        checkOutput("accin_inpsum_ready", DW'(last_in_rdy), DW'(1));
        waitDone("accin_done");

        $display("[TB] backpressure");
        startOp(2'd0);
        exp_q.push_back(pack2(7, -7));
        exp_q.push_back(pack2(8, -8));
        exp_q.push_back(pack2(9, -9));
        exp_q.push_back(pack2(100, -100));
        applyStimulus(7, -7, 1'b0, 0, 0, 1'b0);
        applyStimulus(8, -8, 1'b0, 0, 0, 1'b0);
        applyStimulus(9, -9, 1'b0, 0, 0, 1'b0);
        applyStimulus(100, -100, 1'b1, 0, 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            bus.out_ready = pat[i];
            step();
        end
        bus.out_ready = 1'b1;
        waitDone("bp_done");

        $display("[TB] overflow");
        startOp(2'd0);
        exp_q.push_back(pack2(64'sd4294967295, -5));
        applyStimulus(64'sd4294967295, -5, 1'b1, 0, 0, 1'b0);
        waitDone("ovf_seed_done");
        checkOutput("ovf_seed_flag", DW'(ovf), DW'(0));
        startOp(2'd1);
        exp_q.push_back(pack2(EXP_OVF, -8));
        applyStimulus(1, -3, 1'b1, 0, 0, 1'b0);
        waitDone("ovf_done");
        checkOutput("ovf_flag", DW'(ovf), DW'(1));

        $display("[TB] full");
        startOp(2'd0);
        checkOutput("start_clears_ovf", DW'(ovf), DW'(0));
        checkOutput("start_full_err", DW'(full_err), DW'(0));
        for (int i = 0; i < 64; i++) begin
            applyStimulus(i, -i, 1'b0, 0, 0, 1'b0);
        end
        bus.pe_valid = 1'b1;
        bus.pe_last  = 1'b1;
        @(negedge clk);
        checkOutput("full_pe_ready", DW'(bus.pe_ready), DW'(0));
        step();
        @(negedge clk);
        checkOutput("full_err_set", DW'(full_err), DW'(1));
        checkOutput("full_still_busy", DW'(busy), DW'(1));
        step();
        @(negedge clk);
        checkOutput("full_no_drain", DW'(bus.out_valid), DW'(0));
        bus.pe_valid = 1'b0;
        bus.pe_last  = 1'b0;
        rst = 1'b0;
        #1;
        checkOutput("full_rst_busy", DW'(busy), DW'(0));
        checkOutput("full_rst_err", DW'(full_err), DW'(0));
        step();
        rst = 1'b1;
        step();

        $display("[TB] drain-only with reset mid-drain");
        bus.out_ready = 1'b1;
        startOp(2'd3);
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back(pack2(i, -i));
        end
        hs_base = hs_count;
        waitHs(hs_base + 3);
        step();
        start = 1'b1;
        mode  = 2'd0;
        step();
        start = 1'b0;
        waitHs(hs_base + 10);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("midrst_out_valid", DW'(bus.out_valid), DW'(0));
        checkOutput("midrst_busy", DW'(busy), DW'(0));
        exp_q.delete();
        step();
        rst = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_valid", DW'(bus.out_valid), DW'(0));
        checkOutput("post_rst_done", DW'(done), DW'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
